l1_refill_ctrl: RTL and testbench

//  Sequencer between the direct-mapped L1 instruction/data cache and the byte-wide system bus.

---
 rtl/l1_ctrl_pkg.sv | 6 +
 rtl/l1_refill_ctrl_if.sv | 25 ++
 rtl/l1rc_bus_wdt.sv | 17 +
 rtl/l1_refill_ctrl.sv | 102 ++++++++++
 tb/tb_l1_refill_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/l1_ctrl_pkg.sv
// l1_ctrl_pkg: FSM state encoding and line geometry shared by the L1 cache and its refill controller
package l1_ctrl_pkg;
  localparam int L1_LINE_SIZE = 128;
  localparam int L1_LINE_WID = $clog2(L1_LINE_SIZE);
  typedef enum logic [2:0] {IDLE, LINE, RD, WR, DONE, ERR} state_t;
endpackage

// File: rtl/l1_refill_ctrl_if.sv
// l1_refill_ctrl_if: L1 request/refill port plus byte-wide system bus; master = controller view
interface l1_refill_ctrl_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int LINE_WID = 7
);
  logic read_line_req, read_req, write_through_req;
  logic [ADDR_WIDTH-1:0] pa;
  logic [7:0] wt_data, line_data;
  logic [LINE_WID:0] addr_count;
  logic line_write, cache_entry_refill, trans_rdy, bus_error;
  logic bus_req, bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [7:0] bus_wdata, bus_rdata;
  logic bus_ack, bus_err;
  modport master (
    input read_line_req, read_req, write_through_req, pa, wt_data, bus_rdata, bus_ack, bus_err,
    output line_data, addr_count, line_write, cache_entry_refill, trans_rdy, bus_error,
    output bus_req, bus_we, bus_addr, bus_wdata
  );
  modport slave (
    output read_line_req, read_req, write_through_req, pa, wt_data, bus_rdata, bus_ack, bus_err,
    input line_data, addr_count, line_write, cache_entry_refill, trans_rdy, bus_error,
    input bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/l1rc_bus_wdt.sv
// l1rc_bus_wdt: counts unanswered bus_req cycles and flags a timeout at TIMEOUT
module l1rc_bus_wdt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic bus_req,
  input  logic bus_ack,
  input  logic bus_err,
  output logic timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (rst || !bus_req || bus_ack || bus_err) ? '0 : cnt + 1'b1;
  assign timeout = bus_req && cnt == CW'(TIMEOUT);
endmodule

// File: rtl/l1_refill_ctrl.sv
// l1_refill_ctrl: sequences L1 line refills, uncached reads and write-throughs onto a byte bus; `L1RC_WDT_EN adds a bus watchdog
module l1_refill_ctrl
  import l1_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int LINE_SIZE = L1_LINE_SIZE,
  parameter int LINE_WID = $clog2(LINE_SIZE)
`ifdef L1RC_WDT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input logic clk,
  input logic rst,
  l1_refill_ctrl_if.master b
);
  state_t state;
  logic [LINE_WID-1:0] cnt;
  logic timeout, ok, fail;
`ifdef L1RC_WDT_EN
  l1rc_bus_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .clk(clk), .rst(rst), .bus_req(b.bus_req), .bus_ack(b.bus_ack), .bus_err(b.bus_err), .timeout(timeout)
  );
`else
  assign timeout = 1'b0;
`endif
  // ack/err only count while a beat is actually requested; err wins
  assign fail = b.bus_req && (b.bus_err || timeout);
  assign ok = b.bus_req && b.bus_ack;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      b.line_write <= 1'b0;
      b.cache_entry_refill <= 1'b0;
      b.trans_rdy <= 1'b0;
      b.bus_error <= 1'b0;
      b.bus_req <= 1'b0;
      b.bus_we <= 1'b0;
      b.addr_count <= '0;
      b.line_data <= '0;
      b.bus_addr <= '0;
      b.bus_wdata <= '0;
    end else begin
      b.line_write <= 1'b0;
      b.cache_entry_refill <= 1'b0;
      b.trans_rdy <= 1'b0;
      b.bus_error <= 1'b0;
      case (state)
        IDLE: begin
          if (b.read_line_req) begin
            state <= LINE;
            cnt <= '0;
            b.bus_req <= 1'b1;
            b.bus_we <= 1'b0;
            b.bus_addr <= {b.pa[ADDR_WIDTH-1:LINE_WID], {LINE_WID{1'b0}}};
          end else if (b.write_through_req) begin
            state <= WR;
            b.bus_req <= 1'b1;
            b.bus_we <= 1'b1;
            b.bus_addr <= b.pa;
            b.bus_wdata <= b.wt_data;
          end else if (b.read_req) begin
            state <= RD;
            b.bus_req <= 1'b1;
            b.bus_we <= 1'b0;
            b.bus_addr <= b.pa;
          end
        end
        LINE, RD, WR: begin
          if (fail) begin
            b.bus_req <= 1'b0;
            b.bus_we <= 1'b0;
            b.bus_error <= 1'b1;
            state <= ERR;
          end else if (ok) begin
            b.bus_req <= 1'b0;
            b.bus_we <= 1'b0;
            if (state == LINE) begin
              b.line_write <= 1'b1;
              b.line_data <= b.bus_rdata;
              b.addr_count <= {1'b0, cnt};
              b.bus_addr <= b.bus_addr + 1'b1;
              cnt <= cnt + 1'b1;
              if (cnt == LINE_WID'(LINE_SIZE - 1)) begin
                b.cache_entry_refill <= 1'b1;
                state <= DONE;
              end
            end else begin
              if (state == RD) b.line_data <= b.bus_rdata;
              state <= DONE;
            end
          end else if (!b.bus_req) b.bus_req <= 1'b1;
        end
        DONE: begin
          b.trans_rdy <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l1_refill_ctrl.sv
// tb_l1_refill_ctrl: randomized bench with a transaction-timeline reference model and directed scenarios
module tb_l1_refill_ctrl;
  localparam int AW = 24, LS = 128, LW = 7, TIMEOUT = 255;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  l1_refill_ctrl_if #(.ADDR_WIDTH(AW), .LINE_WID(LW)) bi ();
  l1_refill_ctrl dut (.clk(clk), .rst(rst), .b(bi.master));
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  // reference model: expected pulses scheduled per cycle, bus beats tracked per transaction
  int cyc = 0, free_at = 0, req_at = 0, m_kind = 0, m_beat = 0;
  int s, s1, s2;
  bit m_ok = 0, waiting = 0, eb, fail;
  logic [AW-1:0] m_base, m_addr;
  logic [7:0] m_wd, e_ld, e_ac;
  bit e_lw[4], e_cer[4], e_tr[4], e_be[4];
  int n_lw, n_cer, n_tr, n_be, tr_cyc, ack_cyc, be_cyc, req_rise;
  bit have_first, prev_req;
  logic [AW-1:0] first_addr, last_addr;
  logic first_we;
  logic [7:0] first_wdata;
  always @(negedge clk) begin
    s = cyc % 4;
    s1 = (cyc + 1) % 4;
    s2 = (cyc + 2) % 4;
    if (m_ok) begin
      eb = waiting && cyc >= req_at;
      chk("bus_req", bi.bus_req, eb);
      if (eb) begin
        chk("bus_addr", bi.bus_addr, m_addr);
        chk("bus_we", bi.bus_we, m_kind == 2);
        if (m_kind == 2) chk("bus_wdata", bi.bus_wdata, m_wd);
      end
      chk("line_write", bi.line_write, e_lw[s]);
      chk("cache_entry_refill", bi.cache_entry_refill, e_cer[s]);
      chk("trans_rdy", bi.trans_rdy, e_tr[s]);
      chk("bus_error", bi.bus_error, e_be[s]);
      chk("line_data", bi.line_data, e_ld);
      chk("addr_count", bi.addr_count, e_ac);
      e_lw[s] = 0; e_cer[s] = 0; e_tr[s] = 0; e_be[s] = 0;
      if (bi.bus_req && !prev_req) begin
        req_rise = cyc;
        if (!have_first) begin
          first_addr = bi.bus_addr; first_we = bi.bus_we; first_wdata = bi.bus_wdata; have_first = 1;
        end
      end
      if (bi.bus_req) last_addr = bi.bus_addr;
      if (bi.bus_req && bi.bus_ack && !bi.bus_err) ack_cyc = cyc;
      if (bi.line_write) n_lw++;
      if (bi.cache_entry_refill) n_cer++;
      if (bi.trans_rdy) begin n_tr++; tr_cyc = cyc; end
      if (bi.bus_error) begin n_be++; be_cyc = cyc; end
      prev_req = bi.bus_req;
    end
    if (rst) begin
      m_ok = 1; waiting = 0; free_at = cyc + 1; e_ld = 0; e_ac = 0; prev_req = 0;
      for (int i = 0; i < 4; i++) begin e_lw[i] = 0; e_cer[i] = 0; e_tr[i] = 0; e_be[i] = 0; end
    end else if (m_ok) begin
      if (waiting && cyc >= req_at) begin
        fail = bi.bus_err;
`ifdef L1RC_WDT_EN
        if (cyc - req_at == TIMEOUT) fail = 1;
`endif
        if (fail) begin
          waiting = 0; e_be[s1] = 1; free_at = cyc + 2;
        end else if (bi.bus_ack) begin
          if (m_kind == 0) begin
            e_lw[s1] = 1; e_ld = bi.bus_rdata; e_ac = 8'(m_beat);
            if (m_beat == LS - 1) begin
              e_cer[s1] = 1; e_tr[s2] = 1; waiting = 0; free_at = cyc + 2;
            end else begin
              m_beat++; req_at = cyc + 2; m_addr = m_base + AW'(m_beat);
            end
          end else begin
            if (m_kind == 1) e_ld = bi.bus_rdata;
            e_tr[s2] = 1; waiting = 0; free_at = cyc + 2;
          end
        end
      end else if (!waiting && cyc >= free_at) begin
        if (bi.read_line_req) begin
          m_kind = 0; m_base = {bi.pa[AW-1:LW], {LW{1'b0}}}; m_addr = m_base; m_beat = 0;
        end else if (bi.write_through_req) begin
          m_kind = 2; m_addr = bi.pa; m_wd = bi.wt_data;
        end else if (bi.read_req) begin
          m_kind = 1; m_addr = bi.pa;
        end
        if (bi.read_line_req || bi.write_through_req || bi.read_req) begin
          waiting = 1; req_at = cyc + 1;
        end
      end
    end
    cyc++;
  end
  // bus slave and requester state
  int fixed_dly = -1, err_beat = -1, fix_rd = -1, beat_no, wait_cnt, cur_dly;
  bit hang = 0, jitter = 0;
  task automatic step();
    @(posedge clk);
    #1;
    if (bi.bus_req && !hang) begin
      if (wait_cnt >= cur_dly) begin
        bi.bus_err = (beat_no == err_beat);
        bi.bus_ack = bi.bus_err ? 1'($urandom % 2) : 1'b1;
        bi.bus_rdata = fix_rd >= 0 ? 8'(fix_rd) : 8'($urandom);
        beat_no++;
        wait_cnt = 0;
        cur_dly = fixed_dly >= 0 ? fixed_dly : int'($urandom_range(0, 2));
      end else begin
        bi.bus_ack = 0; bi.bus_err = 0; wait_cnt++;
      end
    end else begin
      bi.bus_ack = 0; bi.bus_err = 0;
    end
    if (jitter) begin bi.pa = AW'($urandom); bi.wt_data = 8'($urandom); end
  endtask
  task automatic set_req(input logic [2:0] m);
    bi.read_line_req = m[2]; bi.write_through_req = m[1]; bi.read_req = m[0];
  endtask
  task automatic run_txn(input logic [2:0] m, input logic [AW-1:0] a, input logic [7:0] d, input int budget);
    bit done = 0;
    bi.pa = a; bi.wt_data = d; set_req(m);
    beat_no = 0; wait_cnt = 0;
    cur_dly = fixed_dly >= 0 ? fixed_dly : int'($urandom_range(0, 2));
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (bi.trans_rdy || bi.bus_error) begin set_req(3'b000); done = 1; end
    end
    set_req(3'b000);
    chk("txn_completes", done, 1);
  endtask
  task automatic clr_mon();
    n_lw = 0; n_cer = 0; n_tr = 0; n_be = 0; have_first = 0;
  endtask
  task automatic rst_chk(input string p);
    chk({p, "_line_write"}, bi.line_write, 0);
    chk({p, "_refill"}, bi.cache_entry_refill, 0);
    chk({p, "_trans_rdy"}, bi.trans_rdy, 0);
    chk({p, "_bus_error"}, bi.bus_error, 0);
    chk({p, "_bus_req"}, bi.bus_req, 0);
    chk({p, "_bus_we"}, bi.bus_we, 0);
    chk({p, "_addr_count"}, bi.addr_count, 0);
    chk({p, "_line_data"}, bi.line_data, 0);
    chk({p, "_bus_addr"}, bi.bus_addr, 0);
    chk({p, "_bus_wdata"}, bi.bus_wdata, 0);
  endtask
  initial begin
    logic [2:0] m;
    set_req(3'b000);
    bi.pa = '0; bi.wt_data = '0; bi.bus_rdata = '0; bi.bus_ack = 0; bi.bus_err = 0;
    repeat (3) step();
    rst_chk("reset");
    rst = 0;
    step();
    clr_mon(); fixed_dly = 1;
    run_txn(3'b100, 24'h012345, 8'h00, 1000);
    repeat (2) step();
    chk("t1_first_addr", first_addr, 24'h012300);
    chk("t1_last_addr", last_addr, 24'h01237F);
    chk("t1_line_writes", n_lw, 128);
    chk("t1_refills", n_cer, 1);
    chk("t1_trans_rdy", n_tr, 1);
    clr_mon(); fix_rd = 8'hA5;
    run_txn(3'b001, 24'h800010, 8'h00, 50);
    repeat (2) step();
    fix_rd = -1;
    chk("t2_bus_we", first_we, 0);
    chk("t2_bus_addr", first_addr, 24'h800010);
    chk("t2_line_data", bi.line_data, 8'hA5);
    chk("t2_latency", tr_cyc - ack_cyc, 2);
    chk("t2_trans_rdy", n_tr, 1);
    clr_mon();
    run_txn(3'b010, 24'h000042, 8'h3C, 50);
    repeat (2) step();
    chk("t3_bus_we", first_we, 1);
    chk("t3_bus_addr", first_addr, 24'h000042);
    chk("t3_bus_wdata", first_wdata, 8'h3C);
    chk("t3_trans_rdy", n_tr, 1);
    clr_mon(); err_beat = 5;
    run_txn(3'b100, AW'($urandom), 8'h00, 1000);
    repeat (2) step();
    err_beat = -1;
    chk("t4_line_writes", n_lw, 5);
    chk("t4_refills", n_cer, 0);
    chk("t4_trans_rdy", n_tr, 0);
    chk("t4_bus_error", n_be, 1);
    clr_mon();
    bi.pa = 24'h00ABCD; bi.wt_data = 8'h11; set_req(3'b111);
    beat_no = 0; wait_cnt = 0; cur_dly = 1;
    repeat (20) step();
    chk("t5_bus_we", first_we, 0);
    chk("t5_bus_addr", first_addr, 24'h00AB80);
    set_req(3'b000);
    rst = 1;
    step();
    rst_chk("t5_rst");
    rst = 0;
    repeat (3) step();
    chk("t5_refills", n_cer, 0);
    chk("t5_trans_rdy", n_tr, 0);
    chk("t5_bus_error", n_be, 0);
`ifdef L1RC_WDT_EN
    clr_mon(); hang = 1;
    run_txn(3'b001, 24'h123456, 8'h00, 400);
    hang = 0;
    repeat (2) step();
    chk("t6_bus_error", n_be, 1);
    chk("t6_timeout_latency", be_cyc - req_rise, 256);
    chk("t6_trans_rdy", n_tr, 0);
`endif
    fixed_dly = -1;
    for (int t = 0; t < 25; t++) begin
      m = 3'($urandom_range(1, 7));
      if (m[2] && ($urandom % 2 == 0)) m[2] = 0;
      if (m == 3'b000) m = 3'b001;
      err_beat = ($urandom % 5 == 0) ? (m[2] ? int'($urandom_range(0, LS - 1)) : 0) : -1;
      jitter = 1;
      run_txn(m, AW'($urandom), 8'($urandom), 2000);
      jitter = 0;
      repeat ($urandom_range(0, 3)) step();
    end
    err_beat = -1;
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
